id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the pipelined MIPS core.
- Captures decoded operands and control from the decode stage each cycle.
- Applies the hazard unit's forwarding selects and the ALUSrc/RegDst choices, then drives the ALU operands (SrcAE/SrcBE), store data, destination register and EX-stage control downstream.
- Forwarding selects come from the external hazard unit; this block does not compute them.

Parameters:
- DW, 32, datapath width of operands, immediate and forwarded results.
- RW, 5, register-specifier width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- FlushE  in  1  synchronous bubble insert from the hazard unit.
- RD1D  in  DW  register-file port 1 data, decode stage.
- RD2D  in  DW  register-file port 2 data, decode stage.
- SignImmD  in  DW  sign-extended immediate.
- RsD  in  RW  rs field.
- RtD  in  RW  rt field.
- RdD  in  RW  rd field.
- RegWriteD  in  1  register write-enable control.
- MemtoRegD  in  1  memory-to-register result-select control.
- MemWriteD  in  1  memory write control.
- ALUSrcD  in  1  1 selects immediate as ALU B operand.
- RegDstD  in  1  1 selects rd as destination, 0 selects rt.
- ALUControlD  in  4  ALU operation code.
- ForwardAE  in  2  A-operand forward select.
- ForwardBE  in  2  B-operand forward select.
- ALUOutM  in  DW  memory-stage ALU result (forward source).
- ResultW  in  DW  writeback result (forward source).
- SrcAE  out  DW  ALU operand A.
- SrcBE  out  DW  ALU operand B.
- WriteDataE  out  DW  forwarded rt data for stores.
- WriteRegE  out  RW  destination register.
- RsE  out  RW  registered rs, to hazard unit.
- RtE  out  RW  registered rt, to hazard unit.
- RegWriteE  out  1  registered control.
- MemtoRegE  out  1  registered control.
- MemWriteE  out  1  registered control.
- ALUControlE  out  4  registered ALU operation code.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Register set: RD1E, RD2E, SignImmE, RsE, RtE, RdE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE.
- Reset (rst_n=0): all registers clear to 0 immediately, without waiting for clk; the outputs follow.
  - SrcAE, SrcBE, WriteDataE, WriteRegE = 0 unless ForwardAE/ForwardBE select a nonzero forward source.
- Register update priority on each rising clk, highest first:
  - rst_n low: hold reset values.
  - FlushE=1: load a bubble, i.e. all registers = 0 (nop: no reg write, no mem write, ALUControlE=0000).
  - Otherwise: load all D-stage inputs.
- Latency: 1 cycle from D inputs to the registered E values. There is no stall input; the hazard unit stalls fetch/decode and flushes this stage.
- Forwarding is combinational from the current-cycle ForwardAE/ForwardBE, ALUOutM and ResultW.
  - ForwardAE: 00 -> RD1E, 01 -> ResultW, 10 -> ALUOutM, 11 -> RD1E (reserved; must not select X).
  - ForwardBE uses the same encoding on RD2E, producing the forwarded B value fwdB.
  - WriteDataE = fwdB.
  - SrcBE = SignImmE when ALUSrcE=1, else fwdB. ALUSrcE overrides ForwardBE for SrcBE only.
- WriteRegE = RdE when RegDstE=1, else RtE (combinational from registered values).
- All arithmetic is pass-through. No width changes: every data path is DW bits.
- FlushE and new D inputs in the same cycle: the flush wins and the D values are discarded.
- Reset asserted mid-pipeline: the in-flight instruction is dropped. The first valid load is the first rising edge after rst_n deasserts.
- No latches; no X on any output after reset.

Test Plan:
- Reset: rst_n=0 asynchronously with RD1D=0x12345678, ForwardAE=ForwardBE=00 -> all outputs 0 before the next clk edge. Release rst_n, one clk -> SrcAE=0x12345678.
- Load: RD1D=5, RD2D=7, RtD=3, RdD=9, RegDstD=1, ALUControlD=0010, RegWriteD=1, Forward=00, one clk -> SrcAE=5, SrcBE=7, WriteRegE=9, ALUControlE=0010, RegWriteE=1.
- Forwarding: after the load above, ALUOutM=0xAAAA0000, ResultW=0x0000BBBB.
  - ForwardAE=10, ForwardBE=01 -> SrcAE=0xAAAA0000, SrcBE=WriteDataE=0x0000BBBB.
  - ForwardAE=11 -> SrcAE=5.
- Immediate select: ALUSrcD=1, SignImmD=0xFFFFFFFC, RD2D=7, ForwardBE=10, ALUOutM=0x11 -> SrcBE=0xFFFFFFFC, WriteDataE=0x11. With RegDstD=0, RtD=4 -> WriteRegE=4.
- Flush: FlushE=1 with RegWriteD=1, MemWriteD=1, RD1D=0x55, one clk -> RegWriteE=MemWriteE=0, ALUControlE=0000, SrcAE=0 (Forward=00). Next clk with FlushE=0 loads normally.
- Mid-operation reset: load a valid instruction, pulse rst_n low for half a cycle between edges -> outputs clear immediately. After release, the next clk loads the current D inputs.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage forwarding and operand selection.
// Forward selects arrive from the hazard unit; this block only applies them.
module id_ex_fwd_mux #(
  parameter int DW = 32
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] reg_val,
  input  logic [DW-1:0] alu_out_m,
  input  logic [DW-1:0] result_w,
  output logic [DW-1:0] y
);
  // 2'b11 is reserved and falls back to the register value, never X
  always_comb begin
    case (sel)
      2'b01:   y = result_w;
      2'b10:   y = alu_out_m;
      default: y = reg_val;
    endcase
  end
endmodule

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          FlushE,
  input  logic [DW-1:0] RD1D,
  input  logic [DW-1:0] RD2D,
  input  logic [DW-1:0] SignImmD,
  input  logic [RW-1:0] RsD,
  input  logic [RW-1:0] RtD,
  input  logic [RW-1:0] RdD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          MemWriteD,
  input  logic          ALUSrcD,
  input  logic          RegDstD,
  input  logic [3:0]    ALUControlD,
  input  logic [1:0]    ForwardAE,
  input  logic [1:0]    ForwardBE,
  input  logic [DW-1:0] ALUOutM,
  input  logic [DW-1:0] ResultW,
  output logic [DW-1:0] SrcAE,
  output logic [DW-1:0] SrcBE,
  output logic [DW-1:0] WriteDataE,
  output logic [RW-1:0] WriteRegE,
  output logic [RW-1:0] RsE,
  output logic [RW-1:0] RtE,
  output logic          RegWriteE,
  output logic          MemtoRegE,
  output logic          MemWriteE,
  output logic [3:0]    ALUControlE
);
  typedef struct packed {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memtoreg;
    logic          memwrite;
    logic          alusrc;
    logic          regdst;
    logic [3:0]    aluctl;
  } idex_t;

  idex_t d, e;

  assign d = '{rd1: RD1D, rd2: RD2D, imm: SignImmD, rs: RsD, rt: RtD, rd: RdD,
               regwrite: RegWriteD, memtoreg: MemtoRegD, memwrite: MemWriteD,
               alusrc: ALUSrcD, regdst: RegDstD, aluctl: ALUControlD};

  // An all-zero register set is the bubble: no reg write, no mem write, ALU op 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      e <= '0;
    else if (FlushE) e <= '0;
    else             e <= d;
  end

  logic [1:0][1:0]    fsel;
  logic [1:0][DW-1:0] rval;
  logic [1:0][DW-1:0] fwd;

  assign fsel = {ForwardBE, ForwardAE};
  assign rval = {e.rd2, e.rd1};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    id_ex_fwd_mux #(.DW(DW)) u_mux (
      .sel       (fsel[i]),
      .reg_val   (rval[i]),
      .alu_out_m (ALUOutM),
      .result_w  (ResultW),
      .y         (fwd[i])
    );
  end

  // ALUSrc overrides forwarding on the B operand only; stores still see fwd B
  assign SrcAE       = fwd[0];
  assign WriteDataE  = fwd[1];
  assign SrcBE       = e.alusrc ? e.imm : fwd[1];
  assign WriteRegE   = e.regdst ? e.rd : e.rt;
  assign RsE         = e.rs;
  assign RtE         = e.rt;
  assign RegWriteE   = e.regwrite;
  assign MemtoRegE   = e.memtoreg;
  assign MemWriteE   = e.memwrite;
  assign ALUControlE = e.aluctl;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          FlushE = 1'b0;
  logic [DW-1:0] RD1D = '0, RD2D = '0, SignImmD = '0;
  logic [RW-1:0] RsD = '0, RtD = '0, RdD = '0;
  logic          RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0;
  logic          ALUSrcD = 1'b0, RegDstD = 1'b0;
  logic [3:0]    ALUControlD = '0;
  logic [1:0]    ForwardAE = '0, ForwardBE = '0;
  logic [DW-1:0] ALUOutM = '0, ResultW = '0;
  logic [DW-1:0] SrcAE, SrcBE, WriteDataE;
  logic [RW-1:0] WriteRegE, RsE, RtE;
  logic          RegWriteE, MemtoRegE, MemWriteE;
  logic [3:0]    ALUControlE;

  int vectors = 0;
  int errors  = 0;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUOutM(ALUOutM), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RsE(RsE), .RtE(RtE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently held in EX, as plain fields
  logic [DW-1:0] m_rd1, m_rd2, m_imm;
  logic [RW-1:0] m_rs, m_rt, m_rd;
  logic          m_rw, m_m2r, m_mw, m_als, m_rdst;
  logic [3:0]    m_alu;

  task automatic model_clear();
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_rw = 0; m_m2r = 0; m_mw = 0; m_als = 0; m_rdst = 0; m_alu = '0;
  endtask

  function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] r);
    if (s == 2'd1) return ResultW;
    if (s == 2'd2) return ALUOutM;
    return r;
  endfunction

  function automatic logic [3*DW+3*RW+7-1:0] expected_bundle();
    logic [DW-1:0] a, b;
    a = pick(ForwardAE, m_rd1);
    b = pick(ForwardBE, m_rd2);
    return {a, (m_als ? m_imm : b), b, (m_rdst ? m_rd : m_rt), m_rs, m_rt,
            m_rw, m_m2r, m_mw, m_alu};
  endfunction

  function automatic logic [3*DW+3*RW+7-1:0] dut_bundle();
    return {SrcAE, SrcBE, WriteDataE, WriteRegE, RsE, RtE,
            RegWriteE, MemtoRegE, MemWriteE, ALUControlE};
  endfunction

  // Advance one rising edge, letting the model take the same decision
  task automatic step();
    @(posedge clk);
    if (!rst_n || FlushE) model_clear();
    else begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = SignImmD; m_rs = RsD; m_rt = RtD; m_rd = RdD;
      m_rw = RegWriteD; m_m2r = MemtoRegD; m_mw = MemWriteD; m_als = ALUSrcD;
      m_rdst = RegDstD; m_alu = ALUControlD;
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    RD1D = 32'h1234_5678; ForwardAE = 2'b00; ForwardBE = 2'b00;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dut_bundle() !== '0) begin
      errors++; $display("FAIL reset_async: got %h want 0", dut_bundle());
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    vectors++;
    if (SrcAE !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_first_load: SrcAE got %h want 12345678", SrcAE);
    end
  endtask

  task automatic test_load();
    RD1D = 5; RD2D = 7; RtD = 3; RdD = 9; RegDstD = 1; ALUControlD = 4'b0010;
    RegWriteD = 1; ALUSrcD = 0; ForwardAE = 0; ForwardBE = 0;
    step();
    vectors++;
    if ({SrcAE, SrcBE, WriteRegE, ALUControlE, RegWriteE} !== {32'd5, 32'd7, 5'd9, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL load: got A=%h B=%h wr=%0d alu=%b rw=%b", SrcAE, SrcBE, WriteRegE, ALUControlE, RegWriteE);
    end
    vectors++;
    if (dut_bundle() !== expected_bundle()) begin
      errors++; $display("FAIL load_model: got %h want %h", dut_bundle(), expected_bundle());
    end
  endtask

  task automatic test_forwarding();
    ALUOutM = 32'hAAAA_0000; ResultW = 32'h0000_BBBB;
    ForwardAE = 2'b10; ForwardBE = 2'b01;
    #1;
    vectors++;
    if ({SrcAE, SrcBE, WriteDataE} !== {32'hAAAA_0000, 32'h0000_BBBB, 32'h0000_BBBB}) begin
      errors++; $display("FAIL forward: got A=%h B=%h WD=%h", SrcAE, SrcBE, WriteDataE);
    end
    ForwardAE = 2'b11;
    #1;
    vectors++;
    if (SrcAE !== 32'd5) begin
      errors++; $display("FAIL forward_reserved: SrcAE got %h want 5", SrcAE);
    end
    ForwardAE = 2'b01;
    #1;
    vectors++;
    if (SrcAE !== 32'h0000_BBBB) begin
      errors++; $display("FAIL forward_a_resultw: SrcAE got %h want 0000bbbb", SrcAE);
    end
    ForwardAE = 0; ForwardBE = 0;
  endtask

  task automatic test_immediate();
    ALUSrcD = 1; SignImmD = 32'hFFFF_FFFC; RD2D = 7; RegDstD = 0; RtD = 4;
    step();
    ForwardBE = 2'b10; ALUOutM = 32'h11;
    #1;
    vectors++;
    if ({SrcBE, WriteDataE, WriteRegE} !== {32'hFFFF_FFFC, 32'h11, 5'd4}) begin
      errors++; $display("FAIL immediate: got B=%h WD=%h wr=%0d", SrcBE, WriteDataE, WriteRegE);
    end
    ForwardBE = 0; ALUSrcD = 0;
  endtask

  task automatic test_flush();
    FlushE = 1; RegWriteD = 1; MemWriteD = 1; RD1D = 32'h55; ALUControlD = 4'b0110;
    ForwardAE = 0; ForwardBE = 0;
    step();
    vectors++;
    if ({RegWriteE, MemWriteE, ALUControlE, SrcAE} !== {1'b0, 1'b0, 4'b0000, 32'd0}) begin
      errors++; $display("FAIL flush: got rw=%b mw=%b alu=%b A=%h", RegWriteE, MemWriteE, ALUControlE, SrcAE);
    end
    FlushE = 0;
    step();
    vectors++;
    if ({SrcAE, RegWriteE, MemWriteE, ALUControlE} !== {32'h55, 1'b1, 1'b1, 4'b0110}) begin
      errors++; $display("FAIL flush_recover: got A=%h rw=%b mw=%b alu=%b", SrcAE, RegWriteE, MemWriteE, ALUControlE);
    end
    MemWriteD = 0;
  endtask

  task automatic test_midreset();
    RD1D = 32'hCAFE_0001; RegWriteD = 1; ALUControlD = 4'b0011;
    step();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dut_bundle() !== '0) begin
      errors++; $display("FAIL midreset_clear: got %h want 0", dut_bundle());
    end
    RD1D = 32'hBEEF_0002;
    #1 rst_n = 1'b1;
    step();
    vectors++;
    if ({SrcAE, RegWriteE, ALUControlE} !== {32'hBEEF_0002, 1'b1, 4'b0011}) begin
      errors++; $display("FAIL midreset_reload: got A=%h rw=%b alu=%b", SrcAE, RegWriteE, ALUControlE);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      FlushE = ($urandom_range(0, 4) == 0);
      RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
      RsD = RW'($urandom); RtD = RW'($urandom); RdD = RW'($urandom);
      RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom); MemWriteD = 1'($urandom);
      ALUSrcD = 1'($urandom); RegDstD = 1'($urandom); ALUControlD = 4'($urandom);
      step();
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ALUOutM = $urandom; ResultW = $urandom;
      #1;
      vectors++;
      if (dut_bundle() !== expected_bundle()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_bundle(), expected_bundle());
      end
    end
    FlushE = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load();
    test_forwarding();
    test_immediate();
    test_flush();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
